// File: rtl/vga_stream_out_if.sv
// vga_stream_out_if
//   Upstream pixel stream (valid/ready) feeding the VGA output stage.
//   pix_data  : {R[7:0],G[7:0],B[7:0]} from the source
//   pix_valid : source has a pixel available
//   pix_ready : output stage takes the pixel this cycle
//   master modport = pixel source, slave modport = vga_stream_out.
interface vga_stream_out_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_stream_out.sv
// vga_stream_out
//   VGA timing generator and output stage. Pulls one upstream pixel per
//   active-area clock, registers RGB/sync/blank towards the DAC, and
//   substitutes ERR_COLOR (with a sticky underflow flag) when the source
//   has nothing to give.
// Ports
//   CLK, NRST      : pixel clock, async active-low reset
//   EN             : timing enable; low parks the raster at (0,0)
//   pix            : upstream pixel stream (slave side)
//   clr_underflow  : synchronous clear of the underflow flag
//   underflow      : sticky underflow flag
//   frame_start    : one-cycle pulse while pixel (0,0) is on the outputs
//   VGA_R/G/B      : registered colour
//   VGA_HS, VGA_VS : registered syncs, active low
//   VGA_BLANK      : registered, high during active video
module vga_stream_out #(
   parameter int          HDISP     = 800,
   parameter int          HFP       = 40,
   parameter int          HPULSE    = 128,
   parameter int          HBP       = 88,
   parameter int          VDISP     = 480,
   parameter int          VFP       = 1,
   parameter int          VPULSE    = 3,
   parameter int          VBP       = 20,
   parameter logic [23:0] ERR_COLOR = 24'hFF00FF
) (
   input  logic              CLK,
   input  logic              NRST,
   input  logic              EN,
   vga_stream_out_if.slave   pix,
   input  logic              clr_underflow,
   output logic              underflow,
   output logic              frame_start,
   output logic [7:0]        VGA_R,
   output logic [7:0]        VGA_G,
   output logic [7:0]        VGA_B,
   output logic              VGA_HS,
   output logic              VGA_VS,
   output logic              VGA_BLANK
);

   localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
   localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [23:0]   rgb;
   logic          active;
   logic          hs_region;
   logic          vs_region;
   logic          frame_origin;

   // Region decode is done in 32-bit int space so a zero back porch
   // cannot overflow the sync-end bound at the counter width.
   always_comb begin
      active       = (int'(hcnt) < HDISP) && (int'(vcnt) < VDISP);
      hs_region    = (int'(hcnt) >= HDISP + HFP) && (int'(hcnt) < HDISP + HFP + HPULSE);
      vs_region    = (int'(vcnt) >= VDISP + VFP) && (int'(vcnt) < VDISP + VFP + VPULSE);
      frame_origin = (hcnt == '0) && (vcnt == '0);
   end

   // Reset parks the counters at (0,0), which is itself an active pixel,
   // so ready is also gated by NRST to keep the source stalled in reset.
   assign pix.pix_ready = active && EN && NRST;

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (!EN) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         rgb         <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK   <= 1'b0;
         frame_start <= 1'b0;
      end else if (!EN) begin
         rgb         <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         VGA_HS      <= !hs_region;
         VGA_VS      <= !vs_region;
         VGA_BLANK   <= active;
         frame_start <= frame_origin;
         if (!active)
            rgb <= '0;
         else if (pix.pix_valid)
            rgb <= pix.pix_data;
         else
            rgb <= ERR_COLOR;
      end
   end

   // Set has priority over clear so a starved pixel is never lost.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST)
         underflow <= 1'b0;
      else if (EN && active && !pix.pix_valid)
         underflow <= 1'b1;
      else if (clr_underflow)
         underflow <= 1'b0;
   end

   assign VGA_R = rgb[23:16];
   assign VGA_G = rgb[15:8];
   assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_vga_stream_out.sv
module tb_vga_stream_out;

   localparam int HD = 4, HF = 1, HP = 2, HB = 1;
   localparam int VD = 3, VF = 1, VP = 1, VB = 1;
   localparam int HT = HD + HF + HP + HB;
   localparam int VT = VD + VF + VP + VB;
   localparam logic [23:0] ERR = 24'hFF00FF;

   logic clk = 1'b0;
   logic nrst;
   logic en;
   logic clr;
   logic underflow, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;
   logic vga_hs, vga_vs, vga_blank;

   always #5 clk = ~clk;

   vga_stream_out_if pix ();

   vga_stream_out #(
      .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
      .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB),
      .ERR_COLOR(ERR)
   ) dut (
      .CLK(clk),
      .NRST(nrst),
      .EN(en),
      .pix(pix),
      .clr_underflow(clr),
      .underflow(underflow),
      .frame_start(frame_start),
      .VGA_R(vga_r),
      .VGA_G(vga_g),
      .VGA_B(vga_b),
      .VGA_HS(vga_hs),
      .VGA_VS(vga_vs),
      .VGA_BLANK(vga_blank)
   );

   typedef struct {
      logic [23:0] rgb;
      logic hs, vs, blank, fs, uf;
   } exp_t;

   exp_t sb[$];
   exp_t me;
   int checks = 0;
   int errors = 0;

   // Reference model: raster position is a linear index into the frame.
   int mt = 0;
   bit muf = 1'b0;
   logic [23:0] word = 24'h000001;
   bit rand_data = 1'b0;
   int consumed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Called 2 time units after a rising edge; returns 2 units after the next.
   task automatic cycle(input bit en_i, input bit valid_i, input bit clr_i);
      exp_t e;
      int h, v;
      bit act;
      h   = mt % HT;
      v   = (mt / HT) % VT;
      act = en_i && (h < HD) && (v < VD);
      en  = en_i;
      clr = clr_i;
      pix.pix_valid = valid_i;
      pix.pix_data  = valid_i ? word : 24'($urandom);
      #1;
      check("pix_ready", {31'd0, pix.pix_ready}, {31'd0, act});
      if (pix.pix_ready && valid_i) consumed++;
      if (act && !valid_i) muf = 1'b1;
      else if (clr_i) muf = 1'b0;
      if (!en_i) begin
         e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.fs = 1'b0;
      end else begin
         e.rgb   = !act ? 24'd0 : (valid_i ? word : ERR);
         e.hs    = !((h >= HD + HF) && (h < HD + HF + HP));
         e.vs    = !((v >= VD + VF) && (v < VD + VF + VP));
         e.blank = act;
         e.fs    = (h == 0) && (v == 0);
      end
      e.uf = muf;
      if (act && valid_i)
         word = rand_data ? 24'($urandom) : word + 24'd1;
      mt = en_i ? (mt + 1) % (HT * VT) : 0;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic run_to(input int h, input int v);
      for (int i = 0; i < HT * VT; i++) begin
         if ((mt % HT) == h && ((mt / HT) % VT) == v) break;
         cycle(1'b1, 1'b1, 1'b0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rgb"}, {8'd0, vga_r, vga_g, vga_b}, 32'd0);
      check({tag, "_sync"}, {28'd0, vga_hs, vga_vs, vga_blank, frame_start}, 32'hC);
      check({tag, "_uf"}, {31'd0, underflow}, 32'd0);
      check({tag, "_ready"}, {31'd0, pix.pix_ready}, 32'd0);
   endtask

   // Monitor: one registered output set appears after every clock edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            me = sb.pop_front();
            check("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, me.rgb});
            check("sync_blank_fs", {28'd0, vga_hs, vga_vs, vga_blank, frame_start},
                  {28'd0, me.hs, me.vs, me.blank, me.fs});
            check("underflow", {31'd0, underflow}, {31'd0, me.uf});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      nrst = 1'b0;
      en = 1'b0;
      clr = 1'b0;
      pix.pix_valid = 1'b1;
      pix.pix_data = 24'h0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("in_reset");
      nrst = 1'b1;

      // Two full frames, always valid, incrementing data.
      repeat (2 * HT * VT) cycle(1'b1, 1'b1, 1'b0);
      check("consumed_2_frames", consumed, 24);

      // Underflow at (2,1), sticky, then cleared; set+clear same cycle.
      run_to(2, 1);
      cycle(1'b1, 1'b0, 1'b0);
      repeat (10) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      run_to(1, 0);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (5) cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);

      // EN low for 3 cycles at (2,1), source starved meanwhile.
      run_to(2, 1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      repeat (60) cycle(1'b1, 1'b1, 1'b0);

      // Randomised traffic.
      rand_data = 1'b1;
      word = 24'($urandom);
      for (int i = 0; i < 400; i++)
         cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 19) == 0));

      // Async reset mid-line with underflow set beforehand.
      run_to(1, 1);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #2;
      nrst = 1'b1;
      mt = 0;
      muf = 1'b0;
      repeat (60) cycle(1'b1, 1'b1, 1'b0);

      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_stream_out.md
Name: vga_stream_out

Overview:
- Video output stage that sits directly downstream of the pixel source inside the `fpga` top level.
- Generates VGA horizontal/vertical timing from pixel-rate counters.
- Pulls pixels from an upstream valid/ready stream during the active area only, and drives registered RGB, sync and blank outputs to the DAC pins.
- Substitutes a fixed error colour and raises a sticky flag when the upstream source underflows.

Parameters:
HDISP, 800, active pixels per line
HFP, 40, horizontal front porch (pixels)
HPULSE, 128, horizontal sync pulse width (pixels)
HBP, 88, horizontal back porch (pixels)
VDISP, 480, active lines per frame
VFP, 1, vertical front porch (lines)
VPULSE, 3, vertical sync pulse width (lines)
VBP, 20, vertical back porch (lines)
ERR_COLOR, 24'hFF00FF, RGB driven on underflow

Ports:
CLK  in  1  pixel clock
NRST  in  1  asynchronous active-low reset
EN  in  1  timing enable (synchronous)
pix_data  in  24  upstream pixel {R[7:0],G[7:0],B[7:0]}
pix_valid  in  1  upstream pixel available
pix_ready  out  1  stage consumes pixel this cycle
clr_underflow  in  1  synchronous clear of underflow flag
underflow  out  1  sticky underflow flag
frame_start  out  1  one-cycle pulse, first pixel of frame on outputs
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK  out  1  low = blanking, high = active video

Behaviour:
- HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP.
- Counter widths are $clog2(HTOTAL) and $clog2(VTOTAL).
- Counters hcnt and vcnt:
  - hcnt increments every cycle while EN=1 and wraps HTOTAL-1 -> 0.
  - vcnt increments when hcnt wraps, and wraps VTOTAL-1 -> 0.
- Line/frame order: active, front porch, sync, back porch.
  - HS region: HDISP+HFP <= hcnt < HDISP+HFP+HPULSE.
  - VS region: same rule on vcnt.
- active = (hcnt < HDISP) && (vcnt < VDISP).
- pix_ready = active && EN. It is combinational from the counters only and never depends on pix_valid.
- A transfer occurs when pix_ready && pix_valid. Upstream may hold pix_valid high outside the active area; nothing is consumed there.
- All video outputs are registered and carry exactly one cycle of latency from the counter state:
  - VGA_HS, VGA_VS and VGA_BLANK(=active) are updated in the cycle after the counter state that produced them.
  - If active && pix_valid: RGB <= pix_data.
  - If active && !pix_valid: RGB <= ERR_COLOR, and underflow <= 1.
  - If not active: RGB <= 0.
- frame_start is registered. It is high for exactly one cycle, coinciding with pixel (0,0) on VGA_*.
- underflow:
  - Sticky until clr_underflow=1.
  - A set and a clear in the same cycle leave underflow at 1 (set wins).
- EN=0:
  - Counters are synchronously forced to (0,0) and pix_ready=0.
  - Next cycle, outputs take their reset values.
  - When EN returns to 1, the frame restarts at (0,0); frame_start fires one cycle after the first enabled cycle.
  - Deasserting EN mid-frame abandons the frame cleanly; underflow is not set.
- Reset (NRST=0, asynchronous, any time, including mid-line):
  - hcnt=0, vcnt=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, frame_start=0, underflow=0.
  - pix_ready=0 while NRST=0.
  - Reset release is assumed synchronised externally.
  - The first count occurs on the first rising edge with NRST=1 and EN=1.

Test Plan:
- All scenarios use small timing: HDISP=4, HFP=1, HPULSE=2, HBP=1 (HTOTAL 8); VDISP=3, VFP=1, VPULSE=1, VBP=1 (VTOTAL 6).
1. Reset, EN=1, pix_valid=1, pix_data = incrementing 24'h000001 upward -> frame_start every 48 cycles; VGA_BLANK high 4 of 8 cycles on lines 0-2; RGB shows 1,2,3,4 on line 0; 12 pixels consumed per frame.
2. Same run, sync checks -> VGA_HS low 2 cycles at line positions 5-6 (output-delayed by 1); VGA_VS low for exactly 8 cycles, on line 4.
3. Drop pix_valid for pixel (2,1) -> that output is 24'hFF00FF; underflow=1 and stays 1; the next pixel is the next upstream word (no skip); clr_underflow pulse -> underflow=0.
4. pix_valid=1 throughout blanking -> pix_ready=0 and no transfer outside the active area; upstream data unchanged until the next active pixel.
5. EN low for 3 cycles at (2,1) -> outputs at reset values; on re-enable, counters restart at (0,0) and frame_start pulses one cycle after the first enabled cycle.
6. Assert NRST=0 asynchronously mid-line (between clock edges) -> outputs take reset values immediately (before the next edge); after release, timing restarts from (0,0); underflow=0.
